fadd_pipe: RTL and testbench

// Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready flow control.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/lzc.sv | 17 +
 rtl/fadd_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default formats, operand classes and the canonical quiet NaN.
// Used by the fadd/fmul/fdiv datapaths.
package fpu_pkg;

  localparam int EW_DEF = 8;
  localparam int MW_DEF = 23;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic              sign;
    logic [EW_DEF-1:0] exp;
    logic [MW_DEF:0]   sig;
  } fp_unpacked_t;

  // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] qnan(input int ew, input int mw);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
    v[mw-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input returns N.
module lzc #(
  parameter int N = 27,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  a,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (a[i]) cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754 adder/subtractor (RNE, flush-to-zero) with valid/ready flow control.
// All stages advance together on en, so a stalled output freezes the whole pipe.
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EW+MW:0] x1,
  input  logic [EW+MW:0] x2,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] y,
  output logic           flg_nx,
  output logic           flg_of,
  output logic           flg_nv
);

  localparam int W     = 1 + EW + MW;
  localparam int SW    = MW + 4;
  localparam int XW    = EW + 2;
  localparam int LZW   = $clog2(SW + 1);
  localparam int SHMAX = MW + 3;
  localparam logic [W-1:0]         QNAN = W'(qnan(EW, MW));
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

  function automatic fp_class_e classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    if (e == '0) return FP_ZERO;
    if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  function automatic logic [MW+1:0] round_rne(input logic [SW-1:0] n);
    logic up;
    up = n[2] & (n[1] | n[0] | n[3]);
    return {1'b0, n[SW-1:3]} + {{(MW + 1){1'b0}}, up};
  endfunction

  // Returns {y, overflow, underflow}; underflow flushes to signed zero.
  function automatic logic [W+1:0] sat_pack(input logic s, input logic signed [XW-1:0] e,
                                            input logic [MW-1:0] m);
    if (e <= 0) return {s, {(W - 1){1'b0}}, 2'b01};
    if (e >= EMAX) return {s, {EW{1'b1}}, {MW{1'b0}}, 2'b10};
    return {s, e[EW-1:0], m, 2'b00};
  endfunction

  logic en;
  logic vld_p1, vld_p2, vld_p3;

  assign en        = !vld_p3 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p3;

  logic          sa, sb, swap;
  logic [EW-1:0] ed, e_big;
  logic [SW-1:0] siga, sigb, sig_b, sig_s, lost, small_al;
  fp_class_e     ca, cb;
  int            sh;
  logic          spec_d, nv_sp_d;
  logic [W-1:0]  spec_y_d;

  always_comb begin
    sa   = x1[W-1];
    sb   = x2[W-1] ^ sub;
    ca   = classify(x1[W-2:MW], x1[MW-1:0]);
    cb   = classify(x2[W-2:MW], x2[MW-1:0]);
    siga = (ca == FP_ZERO) ? '0 : {1'b1, x1[MW-1:0], 3'b000};
    sigb = (cb == FP_ZERO) ? '0 : {1'b1, x2[MW-1:0], 3'b000};
    swap = {x2[W-2:MW], sigb} > {x1[W-2:MW], siga};
    e_big = swap ? x2[W-2:MW] : x1[W-2:MW];
    ed    = swap ? (x2[W-2:MW] - x1[W-2:MW]) : (x1[W-2:MW] - x2[W-2:MW]);
    sig_b = swap ? sigb : siga;
    sig_s = swap ? siga : sigb;
    sh    = (int'(ed) > SHMAX) ? SHMAX : int'(ed);
    lost     = sig_s & ~({SW{1'b1}} << sh);
    small_al = (sig_s >> sh) | {{(SW - 1){1'b0}}, |lost};
    spec_d   = 1'b1;
    nv_sp_d  = 1'b0;
    spec_y_d = '0;
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb)) begin
      spec_y_d = QNAN;
      nv_sp_d  = 1'b1;
    end else if (ca == FP_INF) begin
      spec_y_d = {sa, {EW{1'b1}}, {MW{1'b0}}};
    end else if (cb == FP_INF) begin
      spec_y_d = {sb, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // S1: unpack, compare, align
  logic          sign_p1, zsign_p1, esub_p1, spec_p1, nv_p1;
  logic [EW-1:0] exp_p1;
  logic [SW-1:0] big_p1, small_p1;
  logic [W-1:0]  spec_y_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1    <= in_valid;
      sign_p1   <= swap ? sb : sa;
      zsign_p1  <= sa & sb;
      esub_p1   <= sa ^ sb;
      exp_p1    <= e_big;
      big_p1    <= sig_b;
      small_p1  <= small_al;
      spec_p1   <= spec_d;
      spec_y_p1 <= spec_y_d;
      nv_p1     <= nv_sp_d;
    end
  end

  // S2: add or subtract magnitudes
  logic          sign_p2, zsign_p2, spec_p2, nv_p2;
  logic [EW-1:0] exp_p2;
  logic [SW:0]   sum_p2;
  logic [W-1:0]  spec_y_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p2    <= vld_p1;
      sign_p2   <= sign_p1;
      zsign_p2  <= zsign_p1;
      exp_p2    <= exp_p1;
      sum_p2    <= esub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                           : ({1'b0, big_p1} + {1'b0, small_p1});
      spec_p2   <= spec_p1;
      spec_y_p2 <= spec_y_p1;
      nv_p2     <= nv_p1;
    end
  end

  logic [LZW-1:0]         lz;
  logic [SW-1:0]          norm;
  logic signed [XW-1:0]   exp_n, exp_r;
  logic [MW+1:0]          rnd;
  logic [MW-1:0]          mant;
  logic [W+1:0]           pk;
  logic [W-1:0]           y_d;
  logic                   nx_d, of_d, nv_d;

  lzc #(.N(SW)) u_lzc (
    .a  (sum_p2[SW-1:0]),
    .cnt(lz)
  );

  always_comb begin
    y_d  = '0;
    nx_d = 1'b0;
    of_d = 1'b0;
    nv_d = 1'b0;
    if (sum_p2[SW]) begin
      norm  = {sum_p2[SW:2], |sum_p2[1:0]};
      exp_n = $signed({2'b00, exp_p2}) + XW'(1);
    end else begin
      norm  = sum_p2[SW-1:0] << lz;
      exp_n = $signed({2'b00, exp_p2}) - $signed(XW'(lz));
    end
    rnd   = round_rne(norm);
    exp_r = rnd[MW+1] ? exp_n + XW'(1) : exp_n;
    mant  = rnd[MW+1] ? rnd[MW:1] : rnd[MW-1:0];
    pk    = sat_pack(sign_p2, exp_r, mant);
    if (spec_p2) begin
      y_d  = spec_y_p2;
      nv_d = nv_p2;
    end else if (sum_p2 == '0) begin
      y_d = {zsign_p2, {(W - 1){1'b0}}};
    end else begin
      y_d  = pk[W+1:2];
      of_d = pk[1];
      nx_d = pk[1] | pk[0] | (|norm[2:0]);
    end
  end

  // S3: normalise, round, pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3 <= 1'b0;
      y      <= '0;
      flg_nx <= 1'b0;
      flg_of <= 1'b0;
      flg_nv <= 1'b0;
    end else if (en) begin
      vld_p3 <= vld_p2;
      y      <= y_d;
      flg_nx <= nx_d;
      flg_of <= of_d;
      flg_nv <= nv_d;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Self-checking bench for fadd_pipe (binary32): directed vectors, backpressure,
// randomized traffic against an exact-arithmetic reference, and mid-flight reset.
module tb_fadd_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int W  = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x1 = '0;
  logic [W-1:0] x2 = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         flg_nx, flg_of, flg_nv;

  int n_checks = 0;
  int n_fail   = 0;

  fadd_pipe #(.EW(EW), .MW(MW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .x2       (x2),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .flg_nx   (flg_nx),
    .flg_of   (flg_of),
    .flg_nv   (flg_nv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact reference: operands become integers in units of 2^-149, are summed exactly,
  // then rounded once to 24 bits (RNE). Returns {y, nv, of, nx}.
  function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic                sa, sb, rs, inex;
    int                  ea, eb, p, e, sh;
    logic [22:0]         ma, mb;
    logic signed [300:0] va, vb, tot;
    logic [300:0]        mag, rem, half, q;
    sa = a[31];
    sb = b[31] ^ s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = a[22:0];
    mb = b[22:0];
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sb))
      return {32'h7FC00000, 3'b100};
    if (ea == 255) return {sa, 8'hFF, 23'd0, 3'b000};
    if (eb == 255) return {sb, 8'hFF, 23'd0, 3'b000};
    va = '0;
    vb = '0;
    if (ea != 0) begin
      mag = {277'd0, 1'b1, ma};
      mag = mag << (ea - 1);
      va  = sa ? -$signed(mag) : $signed(mag);
    end
    if (eb != 0) begin
      mag = {277'd0, 1'b1, mb};
      mag = mag << (eb - 1);
      vb  = sb ? -$signed(mag) : $signed(mag);
    end
    tot = va + vb;
    if (tot == 0) return {sa & sb, 31'd0, 3'b000};
    rs  = tot < 0;
    mag = rs ? 301'(-tot) : 301'(tot);
    p = 0;
    for (int i = 0; i < 301; i++) if (mag[i]) p = i;
    e = p - 22;
    inex = 1'b0;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((301'd1 << sh) - 301'd1);
      half = 301'd1 << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 301'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (e < 1) return {rs, 31'd0, 3'b001};
    if (e >= 255) return {rs, 8'hFF, 23'd0, 3'b011};
    return {rs, e[7:0], q[22:0], 2'b00, inex};
  endfunction

  function automatic logic [31:0] rand_op(input logic [7:0] near);
    logic [7:0]  e;
    logic [22:0] m;
    int          k;
    k = $urandom_range(0, 11);
    case (k)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3, 4: e = near + 8'($urandom_range(0, 2)) - 8'd1;
      5:       e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = 23'($urandom);
    k = $urandom_range(0, 7);
    if (k == 0) m = '0;
    else if (k == 1) m = '1;
    return {1'($urandom), e, m};
  endfunction

  // Drives one beat into an idle pipe and waits (bounded) for its result.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] ry, output logic [2:0] rf, output int lat);
    @(negedge clk);
    x1 = a;
    x2 = b;
    sub = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ry = y;
    rf = {flg_nv, flg_of, flg_nx};
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (y !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_y: got %h want 00000000", y);
    end
    n_checks++;
    if ({flg_nv, flg_of, flg_nx} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {flg_nv, flg_of, flg_nx});
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[13], vb[13], vy[13];
    logic        vs[13];
    logic [2:0]  vf[13];
    logic [31:0] ry;
    logic [2:0]  rf;
    int          lat;
    va = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000,
           32'hFF800000, 32'h7FC00001, 32'h80000000, 32'h00800001, 32'h00000001, 32'hC0000000,
           32'h3F800000};
    vb = '{32'h3F800000, 32'h40400000, 32'h33800000, 32'h33800000, 32'h7F7FFFFF, 32'hFF800000,
           32'h3F800000, 32'h00000000, 32'h00000000, 32'h00800000, 32'h3F800000, 32'h3F800000,
           32'h40000000};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vy = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
           32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'hBF800000,
           32'hBF800000};
    vf = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001,
           3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 13; i++) begin
      run_one(va[i], vb[i], vs[i], ry, rf, lat);
      n_checks++;
      if (lat !== 3) begin
        n_fail++;
        $display("FAIL dir[%0d]_latency: got %0d want 3", i, lat);
      end
      n_checks++;
      if (ry !== vy[i]) begin
        n_fail++;
        $display("FAIL dir[%0d]_y: got %h want %h", i, ry, vy[i]);
      end
      n_checks++;
      if (rf !== vf[i]) begin
        n_fail++;
        $display("FAIL dir[%0d]_flags(nv,of,nx): got %b want %b", i, rf, vf[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] q[$];
    logic [34:0] er;
    logic [31:0] a, b, hold_y;
    logic [2:0]  hold_f;
    logic        stalled, saw_block;
    int          sent, got;
    sent = 0;
    got = 0;
    stalled = 1'b0;
    saw_block = 1'b0;
    hold_y = '0;
    hold_f = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      a = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
      x1 = a;
      x2 = b;
      sub = 1'b0;
      in_valid = (sent < 6);
      out_ready = (c >= 5);
      #1;
      if (c == 3) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
        end
      end
      if (stalled) begin
        n_checks++;
        if ({y, flg_nv, flg_of, flg_nx} !== {hold_y, hold_f}) begin
          n_fail++;
          $display("FAIL bp_hold: got %h/%b want %h/%b", y, {flg_nv, flg_of, flg_nx}, hold_y, hold_f);
        end
      end
      stalled = out_valid && !out_ready;
      hold_y = y;
      hold_f = {flg_nv, flg_of, flg_nx};
      if (out_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_spurious: got %h want no output", y);
        end else begin
          er = q.pop_front();
          if ({y, flg_nv, flg_of, flg_nx} !== er) begin
            n_fail++;
            $display("FAIL bp_result[%0d]: got %h/%b want %h/%b", got, y,
                     {flg_nv, flg_of, flg_nx}, er[34:3], er[2:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(a, b, 1'b0));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got !== 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results want 6", got);
    end
    n_checks++;
    if (saw_block !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_blocked: in_ready never dropped while full (got %b want 1)", saw_block);
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] er;
    logic [31:0] a, b;
    logic        s;
    int          got;
    got = 0;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      a = rand_op(8'($urandom_range(1, 254)));
      b = rand_op(a[30:23]);
      s = 1'($urandom);
      x1 = a;
      x2 = b;
      sub = s;
      in_valid = (c < 600) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 600) || ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious: got %h want no output", y);
        end else begin
          er = q.pop_front();
          if ({y, flg_nv, flg_of, flg_nx} !== er) begin
            n_fail++;
            $display("FAIL rnd_result[%0d]: got %h/%b want %h/%b", got, y,
                     {flg_nv, flg_of, flg_nx}, er[34:3], er[2:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) q.push_back(ref_add(a, b, s));
    end
    in_valid = 1'b0;
    n_checks++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d results outstanding want 0", q.size());
    end
  endtask

  task automatic test_reset_flight();
    logic [31:0] ry;
    logic [2:0]  rf;
    logic [34:0] er;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x1 = 32'h40000000 + 32'(i << 20);
      x2 = 32'h3F800000;
      sub = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstfl_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (y !== 32'h0) begin
      n_fail++;
      $display("FAIL rstfl_y: got %h want 00000000", y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    er = ref_add(32'h40A00000, 32'hC0000000, 1'b0);
    run_one(32'h40A00000, 32'hC0000000, 1'b0, ry, rf, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL rstfl_latency: got %0d want 3", lat);
    end
    n_checks++;
    if ({ry, rf} !== er) begin
      n_fail++;
      $display("FAIL rstfl_result: got %h/%b want %h/%b", ry, rf, er[34:3], er[2:0]);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstfl_extra_output: got out_valid %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
